// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : MIPS IF stage. It holds the PC, resolves `j` locally with no
//               bubble, and loads the IF/ID register behind a valid/ready
//               handshake. Redirects from later stages flush IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_ins,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] fetch_count
);

    localparam logic [5:0] c_OP_J = 6'b000010;

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_ins;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic [31:0] r_fetch_count;

    logic        w_adv;
    logic        w_is_j;
    logic [31:0] w_pc4;
    logic [31:0] w_jtarget;
    logic        w_unused;

    always_comb begin
        w_adv     = !r_id_valid || id_ready;
        w_pc4     = r_pc + 32'd4;
        w_is_j    = (imem_ins[31:26] == c_OP_J);
        // The target region comes from pc+4, so it wraps along with the PC.
        w_jtarget = {w_pc4[31:28], imem_ins[25:0], 2'b00};
    end

    // Redirect PCs are forced word aligned; the low bits carry no meaning.
    assign w_unused = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_ins      <= 32'd0;
            r_id_pc       <= 32'd0;
            r_id_pc4      <= 32'd0;
            r_fetch_count <= 32'd0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[31:2], 2'b00};
            r_id_valid <= 1'b0;
            r_id_ins   <= 32'd0;
        end else if (w_adv) begin
            r_pc          <= w_is_j ? w_jtarget : w_pc4;
            r_id_valid    <= 1'b1;
            r_id_ins      <= imem_ins;
            r_id_pc       <= r_pc;
            r_id_pc4      <= w_pc4;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_ins      = r_id_ins;
    assign id_pc       = r_id_pc;
    assign id_pc4      = r_id_pc4;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch: directed scenarios
//               plus random traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_ins;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_ins;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] fetch_count;

    // Second instance for PC wraparound.
    logic        rst2;
    logic [31:0] imem_addr2;
    logic [31:0] word2;
    logic        rv2;
    logic [31:0] rpc2;
    logic        rdy2;
    logic        id_valid2;
    logic [31:0] id_ins2;
    logic [31:0] id_pc2;
    logic [31:0] id_pc4_2;
    logic [31:0] fetch_count2;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ins;
    logic [31:0] m_idpc;
    logic [31:0] m_idpc4;
    logic [31:0] m_cnt;

    assign imem_ins = mem[imem_addr[7:2]];

    instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_ins(imem_ins),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_ins(id_ins),
        .id_pc(id_pc), .id_pc4(id_pc4), .fetch_count(fetch_count)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_ins(word2),
        .redirect_valid(rv2), .redirect_pc(rpc2),
        .id_ready(rdy2), .id_valid(id_valid2), .id_ins(id_ins2),
        .id_pc(id_pc2), .id_pc4(id_pc4_2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    // One clock: drive inputs, advance model by the fetch rules, compare.
    task automatic cycle(input logic a_rst, input logic a_rv, input logic [31:0] a_rpc,
                         input logic a_rdy);
        logic [31:0] w;
        rst            = a_rst;
        redirect_valid = a_rv;
        redirect_pc    = a_rpc;
        id_ready       = a_rdy;
        @(posedge clk);
        if (a_rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_ins = 32'h0;
            m_idpc = 32'h0; m_idpc4 = 32'h0; m_cnt = 32'h0;
        end else if (a_rv) begin
            m_pc = a_rpc & ~32'd3;
            m_valid = 1'b0;
            m_ins = 32'h0;
        end else if (!m_valid || a_rdy) begin
            w = rd(m_pc);
            m_idpc = m_pc;
            m_idpc4 = m_pc + 32'd4;
            m_ins = w;
            m_valid = 1'b1;
            m_cnt = m_cnt + 32'd1;
            if (w[31:26] == 6'b000010)
                m_pc = {m_idpc4[31:28], w[25:0], 2'b00};
            else
                m_pc = m_pc + 32'd4;
        end
        #1;
        chk("addr", imem_addr, m_pc);
        chk("valid", {31'd0, id_valid}, {31'd0, m_valid});
        chk("ins", id_ins, m_ins);
        chk("count", fetch_count, m_cnt);
        if (m_valid) begin
            chk("id_pc", id_pc, m_idpc);
            chk("id_pc4", id_pc4, m_idpc4);
        end
    endtask

    initial begin
        int c;
        logic [31:0] w;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        rst2 = 1'b1; word2 = 32'h0; rv2 = 1'b0; rpc2 = 32'h0; rdy2 = 1'b1;
        mem[0]  = 32'h0022_1820; mem[1] = 32'h2042_0001; mem[2]  = 32'h0085_6024;
        mem[3]  = 32'h00a6_3025; mem[4] = 32'h8c87_0004; mem[5]  = 32'h00c1_2022;
        mem[6]  = 32'h0109_4024; mem[7] = 32'hac48_0008; mem[8]  = 32'h014b_5025;
        mem[9]  = 32'h016c_602a; mem[10] = 32'h0800_0000;
        for (int i = 11; i < 64; i++) mem[i] = 32'h0000_0000;

        // Reset and free run through the j back to 0.
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc4", id_pc4, 32'h0);
        for (int k = 1; k <= 11; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            chk("run_pc", id_pc, 32'(4 * (k - 1)));
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("j_wrap_pc", id_pc, 32'h0);
        chk("j_wrap_cnt", fetch_count, 32'd12);

        // Stall at id_pc = 8.
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("pre_stall_pc", id_pc, 32'd8);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            chk("stall_ins", id_ins, 32'h0085_6024);
            chk("stall_addr", imem_addr, 32'd12);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("post_stall_pc", id_pc, 32'd12);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("pre_redir_pc", id_pc, 32'd16);

        // Redirect with misaligned target.
        c = int'(fetch_count);
        cycle(1'b0, 1'b1, 32'h0000_0017, 1'b1);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_ins", id_ins, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_pc", id_pc, 32'd20);
        chk("redir_tgt_ins", id_ins, 32'h00c1_2022);
        chk("redir_cnt", fetch_count, 32'(c + 1));

        // Redirect during a stall.
        cycle(1'b0, 1'b1, 32'd36, 1'b0);
        chk("rs_bubble", {31'd0, id_valid}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rs_pc", id_pc, 32'd36);

        // Async glitch of rst between edges has no effect.
        rst = 1'b1; #2; rst = 1'b0;
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("glitch_pc", id_pc, 32'd40);

        // Reset mid-stall and mid-redirect.
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'd100, 1'b0);
        chk("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_cnt", fetch_count, 32'd0);
        chk("mid_rst_addr", imem_addr, 32'h0);

        // Random traffic.
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[31:26] = 6'b000010;
            else if (w[31:26] == 6'b000010) w[31:26] = 6'b000000;
            mem[i] = w;
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 3) != 0);
        end

        // PC wraparound on the second instance.
        @(posedge clk); #1;
        chk("wrap_rst_addr", imem_addr2, 32'hFFFF_FFFC);
        rst2 = 1'b0; word2 = 32'h0;
        @(posedge clk); #1;
        chk("wrap_pc0", id_pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4_2, 32'h0);
        chk("wrap_addr", imem_addr2, 32'h0);
        @(posedge clk); #1;
        chk("wrap_pc1", id_pc2, 32'h0);
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0; word2 = 32'h0800_0010;
        @(posedge clk); #1;
        chk("wrap_j_pc", id_pc2, 32'hFFFF_FFFC);
        chk("wrap_j_tgt", imem_addr2, 32'h0000_0040);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the single-issue MIPS core. Owns the program counter, drives the read address of the instruction memory, captures the returned word into the IF/ID pipeline register and hands it to decode with a valid/ready handshake. Resolves `j` (opcode 000010) locally with zero bubbles, and accepts branch/jump redirects from later stages, which flush the IF/ID register.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word aligned.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_addr`  out  32  byte address to instruction memory; always equals the PC register.
- `imem_ins`  in  32  instruction word at `imem_addr`; combinational, valid in the same cycle.
- `redirect_valid`  in  1  later stage demands a PC change (taken branch, `jr`).
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and treated as 00.
- `id_ready`  in  1  decode can accept the word in IF/ID this cycle.
- `id_valid`  out  1  IF/ID holds a live instruction.
- `id_ins`  out  32  fetched instruction.
- `id_pc`  out  32  address of `id_ins`.
- `id_pc4`  out  32  `id_pc` + 4.
- `fetch_count`  out  32  number of words loaded into IF/ID since reset; wraps modulo 2^32.

## Operation
- Internal state: `pc` (32 bits), IF/ID register {`id_valid`, `id_ins`, `id_pc`, `id_pc4`}, `fetch_count`.
- `adv` = !`id_valid` | `id_ready`: the IF/ID register may be overwritten this cycle.
- Next-PC priority, highest first:
  1. `redirect_valid`: `pc` <= {`redirect_pc`[31:2], 2'b00}; `id_valid` <= 0 and `id_ins` <= 0 (flush). Applies even when `adv` = 0.
  2. `adv` & `imem_ins`[31:26] == 6'b000010: `pc` <= {`pc4`[31:28], `imem_ins`[25:0], 2'b00}, where `pc4` = `pc` + 4; IF/ID loads the `j` word (decode treats it as a no-op).
  3. `adv`: `pc` <= `pc` + 4; IF/ID loads {1, `imem_ins`, `pc`, `pc`+4}.
  4. Otherwise (stall): `pc` and IF/ID hold.
- `fetch_count` increments on every load of IF/ID (cases 2 and 3). It does not increment on a flush or a stall.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000. The upper 4 bits of the jump target are taken from `pc`+4, so they wrap with it.
- No other opcode is decoded here. Branches are resolved downstream and arrive only through `redirect_*`.

## Timing
- Reset (`rst` = 1 at an edge): `pc` = `RESET_PC`, `id_valid` = 0, `id_ins` = 0, `id_pc` = 0, `id_pc4` = 0, `fetch_count` = 0.
- `imem_addr` follows `pc` combinationally, so `imem_addr` = `RESET_PC` in the first cycle after reset.
- Latency: the word at PC X is on `id_ins` with `id_valid` = 1 in the cycle after X is presented. In steady flow (`id_ready` = 1), one instruction is delivered per cycle.
- Handshake: a word in IF/ID transfers when `id_valid` & `id_ready`. While `id_valid` = 1 and `id_ready` = 0, all IF/ID outputs are stable.
- `j` costs 0 bubbles; its target is fetched in the cycle right after the `j` is fetched.
- A redirect costs 1 bubble: `id_valid` = 0 for one cycle, then the target word appears.
- Redirect and stall in the same cycle: the redirect wins and the stalled word is discarded.
- Redirect while `imem_ins` is a `j`: the redirect wins and the `j` is dropped.
- Reset mid-stall or mid-redirect: reset overrides everything and all state returns to reset values.

## Test plan
- Reset then free run, `id_ready`=1, memory words 0..10 = add, addi, and, or, lw, sub, and, sw, or, slt, `j 0` (32'h0800_0000) -> `id_pc` runs 0,4,...,40 then 0 with no bubble; `fetch_count` = 12 when `id_pc` = 0 the second time.
- Stall: deassert `id_ready` for 3 cycles while `id_pc` = 8 -> `id_ins` holds 32'h00856024 and `imem_addr` holds 12; after release, `id_pc` = 12 on the next cycle.
- Redirect: `redirect_valid`=1 with `redirect_pc` = 32'h0000_0017 while `id_pc` = 16 -> next cycle `id_valid` = 0 and `id_ins` = 0; the cycle after, `id_pc` = 20 and `id_ins` = 32'h00c12022; `fetch_count` does not count the flushed slot.
- Redirect during stall, with `id_ready`=0 and `redirect_pc` = 36 -> the stalled word is dropped and `id_pc` = 36 after the 1-bubble cycle.
- Wraparound: `RESET_PC` = 32'hFFFF_FFFC, memory returns 32'h0000_0000 -> `id_pc` sequence FFFF_FFFC, 0000_0000. With a `j` at FFFF_FFFC, the target uses upper bits 4'h0.
- Synchronous reset asserted mid-stream for 1 cycle -> the next cycle shows `id_valid` = 0, `fetch_count` = 0 and `imem_addr` = `RESET_PC`. Asynchronous glitches of `rst` between edges have no effect.
